coef_bank_sequencer: RTL and testbench
======================================

Name: coef_bank_sequencer

Overview:
- Parametrised IIR coefficient bank for the recursive filter: holds NumSets sets of NumCoefs signed fixed-point coefficients, each ordered b0, b1, b2, a1, a2.
- Selects the active set and presents it registered to the filter datapath.
- Set changes and run-time coefficient writes are applied only on sample boundaries, so the filter never sees a mixed coefficient set mid-sample.

Parameters:
- Width, 22: coefficient width, signed Q8.14.
- SelBits, 2: set-select width; NumSets = 2**SelBits.
- NumCoefs, 5: coefficients per set, index 0..NumCoefs-1, order b0, b1, b2, a1, a2.
- IdxBits, 3: coefficient index width; must satisfy 2**IdxBits >= NumCoefs.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse marking the filter sample boundary.
- sel  in  SelBits  requested coefficient set.
- wr_en  in  1  coefficient write strobe.
- wr_set  in  SelBits  target set of the write.
- wr_idx  in  IdxBits  target coefficient of the write.
- wr_data  in  Width  value to write.
- wr_err  out  1  one-cycle pulse: write ignored because wr_idx >= NumCoefs.
- coef_out  out  NumCoefs*Width  active coefficients, b0 in the LSBs.
- active_sel  out  SelBits  set currently driving coef_out.
- pending  out  1  a change is waiting for sample_tick.
- switch_done  out  1  one-cycle pulse when coef_out updates.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - Bank loads the default table.
  - coef_out=0, active_sel=0, pending=0, switch_done=0, wr_err=0.
  - FSM goes to IDLE.
  - Reset mid-PENDING discards the pending change.
- Default table (Q8.14):
  - Set 0: all coefficients zero (mute).
  - Sets 1..3: b0=22'h004000 (1.0), b1=b2=a2=0.
  - a1 per set: set 1 = 22'h007FBE (1.996), set 2 = 22'h007D71 (1.960), set 3 = 22'h00423D (1.035).
  - Sets above 3, when SelBits>2: all zero.
- Writes:
  - Bank is updated on the clk edge with wr_en=1 and wr_idx < NumCoefs.
  - wr_idx >= NumCoefs: bank unchanged; wr_err=1 on the next cycle.
  - Writes never change coef_out directly.
- Dirty flag:
  - Set by a valid write to wr_set == active_sel.
  - Set by a valid write to wr_set == target set while in PENDING.
  - Cleared on APPLY.
- FSM states:
  - IDLE: enter PENDING when sel != active_sel or dirty=1. pending=1 from the cycle after the change is detected.
  - PENDING: on sample_tick go to APPLY. If sel returns to active_sel and dirty=0 before the tick, go back to IDLE with no switch_done.
  - APPLY, one cycle: coef_out <= bank[sel], active_sel <= sel, switch_done=1, pending=0, dirty cleared, then IDLE.
- Latency: coef_out changes exactly 1 clk after the sample_tick that is seen in PENDING. Ticks seen in IDLE have no effect.
- sel is sampled at APPLY. The last value before the tick wins; intermediate values are ignored.
- Simultaneous events:
  - A write to the target set on the same edge as APPLY: the new value is not included; dirty stays set, so it applies on the next tick.
  - sample_tick together with the sel change that starts PENDING: the tick is missed; the switch occurs on the next tick.
- Arithmetic: none. Values are stored and output bit-exact, no saturation.

Test Plan:
- Reset, sel=0 → coef_out=0 and active_sel=0. Set sel=1, tick → 1 clk later a1 field=22'h007FBE, b0=22'h004000, single switch_done pulse.
- sel 1→3, hold for 10 clk without tick → pending=1 and coef_out unchanged. Tick → a1=22'h00423D, active_sel=3.
- In set 2, write wr_set=2, wr_idx=4, wr_data=22'h3FF000 → coef_out unchanged, pending=1. Tick → a2 field=22'h3FF000.
- Write with wr_idx=5 → wr_err pulse, bank and coef_out unchanged, no pending.
- sel 1→2→1 before any tick → pending drops, no switch_done, coef_out stays set 1.
- Assert reset_n=0 during PENDING → outputs clear immediately and the bank returns to defaults (set 2 a1 reads 22'h007D71 after reselect).

Source files
------------

// File: rtl/coef_bank_sequencer.sv
// IIR coefficient bank with sample-boundary set switching.
// Bank writes land immediately; coef_out only changes on an APPLY following a sample_tick.
module coef_bank_sequencer #(
  parameter int Width    = 22,
  parameter int SelBits  = 2,
  parameter int NumCoefs = 5,
  parameter int IdxBits  = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_tick,
  input  logic [SelBits-1:0]        sel,
  input  logic                      wr_en,
  input  logic [SelBits-1:0]        wr_set,
  input  logic [IdxBits-1:0]        wr_idx,
  input  logic [Width-1:0]          wr_data,
  output logic                      wr_err,
  output logic [NumCoefs*Width-1:0] coef_out,
  output logic [SelBits-1:0]        active_sel,
  output logic                      pending,
  output logic                      switch_done
);

  // state   | meaning
  // IDLE    | coef_out matches bank[active_sel], nothing outstanding
  // PENDING | new set or dirty coefficients waiting for sample_tick
  // APPLY   | coef_out just reloaded, switch_done high for this cycle
  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  localparam int NumSets = 2 ** SelBits;

  function automatic logic [Width-1:0] dflt(input int s, input int c);
    logic [Width-1:0] v;
    v = '0;
    if (s >= 1 && s <= 3) begin
      if (c == 0) v = Width'(32'h004000);
      if (c == 3) begin
        case (s)
          1:       v = Width'(32'h007FBE);
          2:       v = Width'(32'h007D71);
          default: v = Width'(32'h00423D);
        endcase
      end
    end
    return v;
  endfunction

  state_t                    state_q, state_d;
  logic [Width-1:0]          bank_q [NumSets][NumCoefs];
  logic [Width-1:0]          bank_d [NumSets][NumCoefs];
  logic [NumCoefs*Width-1:0] coef_q, coef_d;
  logic [SelBits-1:0]        active_sel_q, active_sel_d;
  logic                      pending_q, pending_d;
  logic                      switch_done_q, switch_done_d;
  logic                      wr_err_q, wr_err_d;
  logic                      dirty_q, dirty_d;
  logic                      idx_ok, wr_ok, apply_now;

  always_comb begin
    idx_ok        = ({1'b0, wr_idx} < (IdxBits + 1)'(NumCoefs));
    wr_ok         = wr_en && idx_ok;
    wr_err_d      = wr_en && !idx_ok;
    state_d       = state_q;
    bank_d        = bank_q;
    coef_d        = coef_q;
    active_sel_d  = active_sel_q;
    pending_d     = pending_q;
    switch_done_d = 1'b0;
    apply_now     = 1'b0;

    if (wr_ok) bank_d[wr_set][wr_idx] = wr_data;

    case (state_q)
      IDLE: begin
        if (sel != active_sel_q || dirty_q) begin
          state_d   = PENDING;
          pending_d = 1'b1;
        end
      end
      PENDING: begin
        // Nothing left to apply once sel is back and no write touched the live set.
        if (sel == active_sel_q && !dirty_q) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end else if (sample_tick) begin
          state_d   = APPLY;
          apply_now = 1'b1;
          pending_d = 1'b0;
          switch_done_d = 1'b1;
          active_sel_d  = sel;
          for (int c = 0; c < NumCoefs; c++) coef_d[c*Width +: Width] = bank_q[sel][c];
        end
      end
      default: state_d = IDLE;
    endcase

    // A write landing on the apply edge is not in coef_d, so keep the set dirty.
    if (apply_now)
      dirty_d = wr_ok && (wr_set == sel);
    else
      dirty_d = dirty_q || (wr_ok && (wr_set == active_sel_q ||
                                      (state_q == PENDING && wr_set == sel)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      coef_q        <= '0;
      active_sel_q  <= '0;
      pending_q     <= 1'b0;
      switch_done_q <= 1'b0;
      wr_err_q      <= 1'b0;
      dirty_q       <= 1'b0;
      for (int s = 0; s < NumSets; s++)
        for (int c = 0; c < NumCoefs; c++)
          bank_q[s][c] <= dflt(s, c);
    end else begin
      state_q       <= state_d;
      coef_q        <= coef_d;
      active_sel_q  <= active_sel_d;
      pending_q     <= pending_d;
      switch_done_q <= switch_done_d;
      wr_err_q      <= wr_err_d;
      dirty_q       <= dirty_d;
      bank_q        <= bank_d;
    end
  end

  assign coef_out    = coef_q;
  assign active_sel  = active_sel_q;
  assign pending     = pending_q;
  assign switch_done = switch_done_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_coef_bank_sequencer.sv
// Directed bench for coef_bank_sequencer: set switching, deferred writes, write errors, reset.
module tb_coef_bank_sequencer;

  localparam int W = 22;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           sample_tick;
  logic [1:0]     sel;
  logic           wr_en;
  logic [1:0]     wr_set;
  logic [2:0]     wr_idx;
  logic [W-1:0]   wr_data;
  logic           wr_err;
  logic [5*W-1:0] coef_out;
  logic [1:0]     active_sel;
  logic           pending;
  logic           switch_done;

  int checks = 0;
  int failures = 0;

  coef_bank_sequencer dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .sel(sel),
    .wr_en(wr_en), .wr_set(wr_set), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_err(wr_err), .coef_out(coef_out), .active_sel(active_sel),
    .pending(pending), .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5*W-1:0] vec(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                         input logic [W-1:0] b2, input logic [W-1:0] a1,
                                         input logic [W-1:0] a2);
    return {a2, a1, b2, b1, b0};
  endfunction

  function automatic logic [W-1:0] fld(input logic [5*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  logic [5*W-1:0] set1, set2, set3;

  initial begin
    set1 = vec(22'h004000, 0, 0, 22'h007FBE, 0);
    set2 = vec(22'h004000, 0, 0, 22'h007D71, 0);
    set3 = vec(22'h004000, 0, 0, 22'h00423D, 0);
    reset_n = 1'b0; sample_tick = 1'b0; sel = 2'd0;
    wr_en = 1'b0; wr_set = 2'd0; wr_idx = 3'd0; wr_data = '0;
    step(3);
    chk("rst_coef", coef_out, 0);
    chk("rst_active", active_sel, 0);
    chk("rst_flags", {pending, switch_done, wr_err}, 0);
    reset_n = 1'b1;
    step(2);
    chk("idle_no_pending", pending, 0);

    // select set 1
    sel = 2'd1;
    step(1);
    chk("s1_pending", pending, 1);
    chk("s1_coef_before_tick", coef_out, 0);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("s1_a1", fld(coef_out, 3), 22'h007FBE);
    chk("s1_b0", fld(coef_out, 0), 22'h004000);
    chk("s1_done", {switch_done, pending, active_sel}, {1'b1, 1'b0, 2'd1});
    step(1);
    chk("s1_done_single", switch_done, 0);
    chk("s1_full", coef_out, set1);

    // 1 -> 3, held without tick
    sel = 2'd3;
    step(10);
    chk("s3_hold_pending", pending, 1);
    chk("s3_hold_coef", coef_out, set1);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("s3_a1", fld(coef_out, 3), 22'h00423D);
    chk("s3_active", {active_sel, switch_done}, {2'd3, 1'b1});

    // move to set 2
    step(1);
    sel = 2'd2;
    step(2);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("s2_full", coef_out, set2);
    step(1);

    // write a2 of active set 2
    wr_en = 1'b1; wr_set = 2'd2; wr_idx = 3'd4; wr_data = 22'h3FF000;
    step(1);
    wr_en = 1'b0;
    chk("wr_coef_unchanged", coef_out, set2);
    chk("wr_no_err", wr_err, 0);
    step(2);
    chk("wr_pending", pending, 1);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("wr_a2", fld(coef_out, 4), 22'h3FF000);
    chk("wr_a1_kept", fld(coef_out, 3), 22'h007D71);
    chk("wr_done", switch_done, 1);
    step(2);
    chk("wr_dirty_cleared", pending, 0);

    // out-of-range index
    wr_en = 1'b1; wr_set = 2'd2; wr_idx = 3'd5; wr_data = 22'h123456;
    step(1);
    wr_en = 1'b0;
    chk("err5_pulse", wr_err, 1);
    step(1);
    chk("err5_single", wr_err, 0);
    chk("err5_no_pending", pending, 0);
    chk("err5_coef", coef_out, vec(22'h004000, 0, 0, 22'h007D71, 22'h3FF000));
    wr_en = 1'b1; wr_set = 2'd2; wr_idx = 3'd7;
    step(1);
    wr_en = 1'b0;
    chk("err7_pulse", wr_err, 1);
    step(2);
    chk("err7_no_pending", pending, 0);

    // back to set 1, then 1 -> 2 -> 1 with no tick
    sel = 2'd1;
    step(2);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("back_s1", {active_sel, coef_out}, {2'd1, set1});
    step(1);
    sel = 2'd2;
    step(2);
    chk("bounce_pending", pending, 1);
    sel = 2'd1;
    step(1);
    chk("bounce_drop", pending, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bounce_no_done", switch_done, 0);
    end
    chk("bounce_coef", coef_out, set1);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("idle_tick_ignored", {switch_done, pending}, 0);

    // tick coincident with the sel change is missed
    sel = 2'd3; sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("coinc_missed", {switch_done, pending, active_sel}, {1'b0, 1'b1, 2'd1});
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("coinc_next_tick", {switch_done, active_sel}, {1'b1, 2'd3});
    step(1);

    // write to the target set on the apply edge is deferred
    sel = 2'd2;
    step(2);
    sample_tick = 1'b1;
    wr_en = 1'b1; wr_set = 2'd2; wr_idx = 3'd0; wr_data = 22'h011111;
    step(1);
    sample_tick = 1'b0; wr_en = 1'b0;
    chk("race_old_b0", {switch_done, fld(coef_out, 0)}, {1'b1, 22'h004000});
    step(2);
    chk("race_repending", pending, 1);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("race_new_b0", fld(coef_out, 0), 22'h011111);
    step(1);

    // reset in PENDING restores defaults
    sel = 2'd3;
    step(2);
    chk("rst2_pending", pending, 1);
    reset_n = 1'b0;
    #1;
    chk("rst2_async", {coef_out, active_sel, pending, switch_done}, 0);
    step(1);
    reset_n = 1'b1;
    sel = 2'd2;
    step(2);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("rst2_default_set2", coef_out, set2);
    chk("rst2_a1", fld(coef_out, 3), 22'h007D71);

    // mute set 0
    step(1);
    sel = 2'd0;
    step(2);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("mute_set0", {active_sel, coef_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
